flash_verify_seq: RTL and testbench
===================================

Name: flash_verify_seq

Overview:
- Self-test sequencer that drives the SPI flash controller's user op interface.
- On a start pulse it issues three operations in order:
  - a sector erase at the base address;
  - a page program of a deterministic byte pattern;
  - a read-back of the same range.
- It compares every returned byte against the pattern and reports pass/fail plus an error count.
- It sits between board-level test logic (button/UART command) and the flash controller, acting as the controller's sole requester.

Parameters:
- SEED, 8'hA5, first pattern byte; byte k = (SEED + k) mod 256.
- TIMEOUT_CYC, 50_000_000, max cycles in any wait state before aborting with failure.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle start pulse
- i_base_addr  in  24  flash start address of test range
- i_len  in  9  byte count, legal 1..256
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle completion pulse
- o_pass  out  1  result, valid from o_done until next accepted start
- o_err_cnt  out  9  mismatching/missing byte count
- o_op_type  out  2  0=sector erase, 1=page program, 2=read
- o_op_addr  out  24  op address
- o_op_num  out  9  op byte count
- o_op_valid  out  1  op request
- i_op_ready  in  1  controller idle/accepting
- o_write_data  out  8  program byte
- o_write_sop  out  1  first program byte
- o_write_eop  out  1  last program byte
- o_write_valid  out  1  program byte valid
- i_read_data  in  8  read byte
- i_read_sop  in  1  first read byte
- i_read_eop  in  1  last read byte
- i_read_valid  in  1  read byte valid

Behaviour:
- Clocking and reset:
  - Single clock i_clk.
  - i_rst is synchronous, active-high, and forces IDLE.
  - All outputs reset to 0, including o_pass and o_err_cnt.
  - Reset mid-operation abandons the sequence immediately; the current op/stream is not completed.
- Start:
  - i_start is accepted only in IDLE; it is ignored while o_busy.
  - On acceptance, i_base_addr and i_len are latched, o_err_cnt is cleared, and o_busy is set the next cycle.
- Range check:
  - Reject if i_len==0, i_len>256, or (i_base_addr[7:0] + i_len) > 256 (page crossing).
  - On reject: no op is issued; o_done pulses 1 cycle after start with o_pass=0 and o_err_cnt=0.
- Op handshake:
  - o_op_type/addr/num/valid are held stable until a cycle with o_op_valid && i_op_ready, which is the accept.
  - o_op_valid drops the cycle after the accept.
- Wait rule: after each accept, the sequencer waits until it has seen i_op_ready==0 at least one cycle and then i_op_ready==1.
- States:
  - IDLE -> ERASE_REQ: type 0, addr = base & 24'hFFF000, num 0.
  - ERASE_REQ -> ERASE_WAIT.
  - ERASE_WAIT -> PROG_REQ: type 1, addr base, num len.
  - PROG_REQ -> PROG_DATA:
    - starts the cycle after the accept;
    - len bytes on consecutive cycles, o_write_valid=1, sop on byte 0, eop on byte len-1 (both on the same cycle if len==1);
    - no backpressure.
  - PROG_DATA -> PROG_WAIT -> READ_REQ: type 2, addr base, num len.
  - READ_REQ -> READ_DATA: each i_read_valid byte k is compared to SEED+k; a mismatch increments o_err_cnt (saturating at 511).
  - READ_DATA exits on a valid byte with i_read_eop:
    - fewer than len bytes received: add (len - received) to o_err_cnt;
    - extra bytes arriving after eop are ignored.
  - READ_DATA -> DONE: o_done=1 for one cycle, o_pass = (o_err_cnt==0), o_busy drops in the same cycle -> IDLE.
- i_read_valid outside READ_DATA is ignored.
- Timeout:
  - A single counter, reset on entry to each REQ/WAIT/READ_DATA state.
  - Reaching TIMEOUT_CYC jumps to DONE with o_pass=0 and o_err_cnt unchanged; o_op_valid is deasserted.

Optional Feature:
- FLASH_SEQ_ERR_CAPTURE_EN
- Defined: adds outputs o_err_addr[23:0], o_err_exp[7:0], o_err_got[7:0]. These capture the absolute address, expected byte and received byte of the first mismatch in a run. They are cleared to 0 on reset and on an accepted start, and hold until the next start.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Start, base 24'h012300, len 16, model returns SEED+k -> ops in order: type0 addr 012000, type1 num16, type2 num16; write bytes A5..B4 with sop/eop on bytes 0/15; o_done with o_pass=1, err_cnt=0.
- Same run, model corrupts byte 3 (returns 8'h00) -> o_pass=0, err_cnt=1; with the macro: err_addr 012303, exp A8, got 00.
- len=0, len=257, and base 0x0000F0 with len 32 -> o_done 1 cycle after start, o_pass=0, o_op_valid never asserted.
- Model asserts read eop after 10 of 16 bytes -> err_cnt=6, o_pass=0.
- Model holds i_op_ready=0 forever after the erase accept, TIMEOUT_CYC=100 -> o_done ~100 cycles later, o_pass=0.
- Assert i_rst during PROG_DATA byte 5; also pulse i_start while busy -> all outputs 0 next cycle, no further write_valid; the start pulse while busy has no effect.

Source files
------------

// File: rtl/flash_verify_seq.sv
// flash_verify_seq: erase / program / read-back self test on the flash op port.
// Define FLASH_SEQ_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module flash_verify_seq #(
   parameter logic [7:0] SEED        = 8'hA5,
   parameter int         TIMEOUT_CYC = 50_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [23:0] i_base_addr,
   input  logic [8:0]  i_len,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [8:0]  o_err_cnt,
   output logic [1:0]  o_op_type,
   output logic [23:0] o_op_addr,
   output logic [8:0]  o_op_num,
   output logic        o_op_valid,
   input  logic        i_op_ready,
   output logic [7:0]  o_write_data,
   output logic        o_write_sop,
   output logic        o_write_eop,
   output logic        o_write_valid,
   input  logic [7:0]  i_read_data,
   input  logic        i_read_sop,
   input  logic        i_read_eop,
   input  logic        i_read_valid
`ifdef FLASH_SEQ_ERR_CAPTURE_EN
   ,
   output logic [23:0] o_err_addr,
   output logic [7:0]  o_err_exp,
   output logic [7:0]  o_err_got
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ERASE_REQ,
      S_ERASE_WAIT,
      S_PROG_REQ,
      S_PROG_DATA,
      S_PROG_WAIT,
      S_READ_REQ,
      S_READ_DATA,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [23:0]   base;
   logic [8:0]    len;
   logic [8:0]    wr_idx;
   logic [8:0]    rd_cnt;
   logic [TW-1:0] tcnt;
   logic          seen_low;
   logic          range_ok;
   logic          tmo;
   logic          accept;
   logic          take;
   logic          mis;
   logic          pass_n;
   logic [7:0]    exp_byte;
   logic [9:0]    rcv;
   logic [10:0]   sum;
   logic [8:0]    err_n;
   logic          unused_ok;

   // start sop is implied by the byte counter; the input is informational
   assign unused_ok = i_read_sop;

   assign range_ok = (i_len != 9'd0) && (i_len <= 9'd256) &&
                     (({2'b00, i_base_addr[7:0]} + {1'b0, i_len}) <= 10'd256);
   assign tmo      = (tcnt == TW'(TIMEOUT_CYC - 1));
   assign accept   = o_op_valid && i_op_ready;
   assign take     = (state == S_READ_DATA) && i_read_valid && !tmo;

   // error count for the byte being taken, including shortfall on early eop
   always_comb begin
      exp_byte = SEED + rd_cnt[7:0];
      mis      = (i_read_data != exp_byte);
      rcv      = {1'b0, rd_cnt} + 10'd1;
      sum      = {2'b00, o_err_cnt} + {10'd0, mis};
      if (i_read_eop && (rcv < {1'b0, len}))
         sum = sum + {1'b0, ({1'b0, len} - rcv)};
      err_n    = (sum > 11'd511) ? 9'd511 : sum[8:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n       = state;
      pass_n        = 1'b0;
      o_busy        = 1'b1;
      o_done        = 1'b0;
      o_op_valid    = 1'b0;
      o_op_type     = 2'd0;
      o_op_addr     = 24'd0;
      o_op_num      = 9'd0;
      o_write_valid = 1'b0;
      o_write_data  = 8'd0;
      o_write_sop   = 1'b0;
      o_write_eop   = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_n = range_ok ? S_ERASE_REQ : S_DONE;
         end
         S_ERASE_REQ: begin
            o_op_valid = !tmo;
            o_op_type  = 2'd0;
            o_op_addr  = {base[23:12], 12'h000};
            if (tmo)             state_n = S_DONE;
            else if (i_op_ready) state_n = S_ERASE_WAIT;
         end
         S_ERASE_WAIT: begin
            if (tmo)                          state_n = S_DONE;
            else if (seen_low && i_op_ready)  state_n = S_PROG_REQ;
         end
         S_PROG_REQ: begin
            o_op_valid = !tmo;
            o_op_type  = 2'd1;
            o_op_addr  = base;
            o_op_num   = len;
            if (tmo)             state_n = S_DONE;
            else if (i_op_ready) state_n = S_PROG_DATA;
         end
         S_PROG_DATA: begin
            o_write_valid = 1'b1;
            o_write_data  = SEED + wr_idx[7:0];
            o_write_sop   = (wr_idx == 9'd0);
            o_write_eop   = (wr_idx == len - 9'd1);
            if (wr_idx == len - 9'd1) state_n = S_PROG_WAIT;
         end
         S_PROG_WAIT: begin
            if (tmo)                          state_n = S_DONE;
            else if (seen_low && i_op_ready)  state_n = S_READ_REQ;
         end
         S_READ_REQ: begin
            o_op_valid = !tmo;
            o_op_type  = 2'd2;
            o_op_addr  = base;
            o_op_num   = len;
            if (tmo)             state_n = S_DONE;
            else if (i_op_ready) state_n = S_READ_DATA;
         end
         S_READ_DATA: begin
            if (tmo) state_n = S_DONE;
            else if (i_read_valid && i_read_eop) begin
               state_n = S_DONE;
               pass_n  = (err_n == 9'd0);
            end
         end
         S_DONE: begin
            o_busy  = 1'b0;
            o_done  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         base      <= '0;
         len       <= '0;
         wr_idx    <= '0;
         rd_cnt    <= '0;
         tcnt      <= '0;
         seen_low  <= 1'b0;
         o_err_cnt <= '0;
         o_pass    <= 1'b0;
      end else begin
         tcnt <= (state_n != state) ? '0 : tcnt + 1'b1;
         if (state == S_IDLE && i_start) begin
            base      <= i_base_addr;
            len       <= i_len;
            o_err_cnt <= '0;
            o_pass    <= 1'b0;
         end
         // controller must go busy then idle again after each accept
         if (accept)           seen_low <= 1'b0;
         else if (!i_op_ready) seen_low <= 1'b1;
         wr_idx <= (state == S_PROG_DATA) ? wr_idx + 9'd1 : 9'd0;
         if (state != S_READ_DATA) rd_cnt <= '0;
         else if (take) begin
            o_err_cnt <= err_n;
            if (rd_cnt != 9'd511) rd_cnt <= rd_cnt + 9'd1;
         end
         if (state_n == S_DONE && state != S_DONE) o_pass <= pass_n;
      end
   end

`ifdef FLASH_SEQ_ERR_CAPTURE_EN
   logic cap_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cap_done   <= 1'b0;
         o_err_addr <= '0;
         o_err_exp  <= '0;
         o_err_got  <= '0;
      end else if (state == S_IDLE && i_start) begin
         cap_done   <= 1'b0;
         o_err_addr <= '0;
         o_err_exp  <= '0;
         o_err_got  <= '0;
      end else if (take && mis && !cap_done) begin
         cap_done   <= 1'b1;
         o_err_addr <= base + {15'd0, rd_cnt};
         o_err_exp  <= exp_byte;
         o_err_got  <= i_read_data;
      end
   end
`endif

endmodule

// File: tb/tb_flash_verify_seq.sv
// tb_flash_verify_seq: directed scenarios for flash_verify_seq driven by a
// small behavioural flash-controller model.
`timescale 1ns/1ps
module tb_flash_verify_seq;

   localparam logic [7:0] SEED = 8'hA5;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [23:0] base;
   logic [8:0]  len;
   logic        busy, done, pass;
   logic [8:0]  err_cnt;
   logic [1:0]  op_type;
   logic [23:0] op_addr;
   logic [8:0]  op_num;
   logic        op_valid, op_ready;
   logic [7:0]  write_data;
   logic        write_sop, write_eop, write_valid;
   logic [7:0]  read_data;
   logic        read_sop, read_eop, read_valid;
`ifdef FLASH_SEQ_ERR_CAPTURE_EN
   logic [23:0] err_addr;
   logic [7:0]  err_exp, err_got;
`endif

   int n_vec = 0;
   int n_miss = 0;

   // controller model knobs
   int corrupt_idx = -1;
   int eop_at = 0;
   int extra = 0;
   bit hang = 0;

   logic [1:0]  op_t[$];
   logic [23:0] op_a[$];
   logic [8:0]  op_n[$];
   logic [7:0]  wq_d[$];
   logic        wq_s[$];
   logic        wq_e[$];
   int          opv_cnt = 0;

   bit          got;
   int          lat;
   logic        d_pass, d_busy, d_opv;
   logic [8:0]  d_err;

   always #5 clk = ~clk;

   flash_verify_seq #(.SEED(SEED), .TIMEOUT_CYC(100)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_base_addr(base), .i_len(len),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
      .o_op_type(op_type), .o_op_addr(op_addr), .o_op_num(op_num),
      .o_op_valid(op_valid), .i_op_ready(op_ready),
      .o_write_data(write_data), .o_write_sop(write_sop),
      .o_write_eop(write_eop), .o_write_valid(write_valid),
      .i_read_data(read_data), .i_read_sop(read_sop),
      .i_read_eop(read_eop), .i_read_valid(read_valid)
`ifdef FLASH_SEQ_ERR_CAPTURE_EN
      , .o_err_addr(err_addr), .o_err_exp(err_exp), .o_err_got(err_got)
`endif
   );

   initial begin : ctrl_model
      int n, nb;
      logic [1:0] t;
      op_ready = 1'b1;
      read_valid = 1'b0; read_data = 8'h00; read_sop = 1'b0; read_eop = 1'b0;
      forever begin
         @(negedge clk);
         if (op_valid && op_ready && !rst) begin
            t = op_type;
            n = int'(op_num);
            op_t.push_back(op_type);
            op_a.push_back(op_addr);
            op_n.push_back(op_num);
            @(negedge clk);
            op_ready = 1'b0;
            while (hang) @(negedge clk);
            if (t == 2'd2) begin
               nb = (eop_at > 0) ? eop_at : n;
               for (int k = 0; k < nb + extra; k++) begin
                  read_valid = 1'b1;
                  if (k >= nb)               read_data = 8'h11;
                  else if (k == corrupt_idx) read_data = 8'h00;
                  else                       read_data = SEED + 8'(k);
                  read_sop = (k == 0);
                  read_eop = (k == nb - 1);
                  @(negedge clk);
               end
               read_valid = 1'b0; read_sop = 1'b0; read_eop = 1'b0;
               read_data = 8'h00;
            end else begin
               repeat (n + 3) @(negedge clk);
            end
            op_ready = 1'b1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (write_valid) begin
            wq_d.push_back(write_data);
            wq_s.push_back(write_sop);
            wq_e.push_back(write_eop);
         end
         if (op_valid) opv_cnt++;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      op_t.delete(); op_a.delete(); op_n.delete();
      wq_d.delete(); wq_s.delete(); wq_e.delete();
      opv_cnt = 0;
   endtask

   task automatic run_seq(input logic [23:0] b, input logic [8:0] l,
                          input int limit);
      repeat (5) @(negedge clk);
      clear_logs();
      base = b; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0; lat = 0;
      for (int i = 1; i <= limit && !got; i++) begin
         if (done) begin
            got = 1; lat = i;
            d_pass = pass; d_err = err_cnt; d_busy = busy; d_opv = op_valid;
         end else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; base = '0; len = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, done, pass, err_cnt} !== 12'd0) begin
         n_miss++;
         $display("FAIL reset_status: got %h want 000", {busy, done, pass, err_cnt});
      end
      n_vec++;
      if ({op_valid, op_type, op_addr, op_num, write_valid, write_sop,
           write_eop, write_data} !== '0) begin
         n_miss++;
         $display("FAIL reset_ports: op_valid %b write_valid %b want 0", op_valid, write_valid);
      end
`ifdef FLASH_SEQ_ERR_CAPTURE_EN
      n_vec++;
      if ({err_addr, err_exp, err_got} !== 40'd0) begin
         n_miss++;
         $display("FAIL reset_capture: got %h want 0", {err_addr, err_exp, err_got});
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_seq(24'h012300, 9'd16, 400);
      n_vec++;
      if (got !== 1'b1) begin n_miss++; $display("FAIL basic_done: got %b want 1", got); end
      n_vec++;
      if (op_t.size() !== 3) begin n_miss++; $display("FAIL basic_opcount: got %0d want 3", op_t.size()); end
      if (op_t.size() == 3) begin
         n_vec++;
         if ({op_t[0], op_a[0], op_n[0]} !== {2'd0, 24'h012000, 9'd0}) begin
            n_miss++; $display("FAIL basic_erase: got %h %h %h want 0 012000 000", op_t[0], op_a[0], op_n[0]);
         end
         n_vec++;
         if ({op_t[1], op_a[1], op_n[1]} !== {2'd1, 24'h012300, 9'd16}) begin
            n_miss++; $display("FAIL basic_prog: got %h %h %h want 1 012300 010", op_t[1], op_a[1], op_n[1]);
         end
         n_vec++;
         if ({op_t[2], op_a[2], op_n[2]} !== {2'd2, 24'h012300, 9'd16}) begin
            n_miss++; $display("FAIL basic_read: got %h %h %h want 2 012300 010", op_t[2], op_a[2], op_n[2]);
         end
      end
      n_vec++;
      if (wq_d.size() !== 16) begin n_miss++; $display("FAIL basic_wcount: got %0d want 16", wq_d.size()); end
      if (wq_d.size() == 16) begin
         for (int k = 0; k < 16; k++) begin
            n_vec++;
            if ({wq_d[k], wq_s[k], wq_e[k]} !== {SEED + 8'(k), k == 0, k == 15}) begin
               n_miss++;
               $display("FAIL basic_wbyte%0d: got %h sop %b eop %b want %h", k, wq_d[k], wq_s[k], wq_e[k], SEED + 8'(k));
            end
         end
      end
      n_vec++;
      if ({d_pass, d_err, d_busy} !== {1'b1, 9'd0, 1'b0}) begin
         n_miss++; $display("FAIL basic_result: pass %b err %0d busy %b want 1 0 0", d_pass, d_err, d_busy);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (pass !== 1'b1) begin n_miss++; $display("FAIL basic_pass_hold: got %b want 1", pass); end
   endtask

   task automatic test_corrupt();
      corrupt_idx = 3;
      run_seq(24'h012300, 9'd16, 400);
      corrupt_idx = -1;
      n_vec++;
      if ({got, d_pass, d_err} !== {1'b1, 1'b0, 9'd1}) begin
         n_miss++; $display("FAIL corrupt_result: done %b pass %b err %0d want 1 0 1", got, d_pass, d_err);
      end
`ifdef FLASH_SEQ_ERR_CAPTURE_EN
      n_vec++;
      if ({err_addr, err_exp, err_got} !== {24'h012303, 8'hA8, 8'h00}) begin
         n_miss++; $display("FAIL corrupt_capture: got %h %h %h want 012303 a8 00", err_addr, err_exp, err_got);
      end
`endif
   endtask

   task automatic test_reject();
      logic [23:0] rb[3];
      logic [8:0]  rl[3];
      rb[0] = 24'h012300; rl[0] = 9'd0;
      rb[1] = 24'h012300; rl[1] = 9'd257;
      rb[2] = 24'h0000F0; rl[2] = 9'd32;
      for (int v = 0; v < 3; v++) begin
         run_seq(rb[v], rl[v], 20);
         n_vec++;
         if ({got, lat} !== {1'b1, 32'd1}) begin
            n_miss++; $display("FAIL reject%0d_latency: done %b lat %0d want 1 1", v, got, lat);
         end
         n_vec++;
         if ({d_pass, d_err} !== {1'b0, 9'd0}) begin
            n_miss++; $display("FAIL reject%0d_result: pass %b err %0d want 0 0", v, d_pass, d_err);
         end
         repeat (3) @(negedge clk);
         n_vec++;
         if (opv_cnt !== 0) begin
            n_miss++; $display("FAIL reject%0d_noop: op_valid cycles %0d want 0", v, opv_cnt);
         end
      end
   endtask

   task automatic test_short_eop();
      eop_at = 10; extra = 2;
      run_seq(24'h012300, 9'd16, 400);
      n_vec++;
      if ({got, d_pass, d_err} !== {1'b1, 1'b0, 9'd6}) begin
         n_miss++; $display("FAIL short_result: done %b pass %b err %0d want 1 0 6", got, d_pass, d_err);
      end
      repeat (5) @(negedge clk);
      eop_at = 0; extra = 0;
      n_vec++;
      if ({pass, err_cnt, busy} !== {1'b0, 9'd6, 1'b0}) begin
         n_miss++; $display("FAIL short_extra_ignored: pass %b err %0d busy %b want 0 6 0", pass, err_cnt, busy);
      end
   endtask

   task automatic test_boundary();
      run_seq(24'h3456FF, 9'd1, 400);
      n_vec++;
      if ({got, d_pass, d_err} !== {1'b1, 1'b1, 9'd0}) begin
         n_miss++; $display("FAIL len1_result: done %b pass %b err %0d want 1 1 0", got, d_pass, d_err);
      end
      n_vec++;
      if (wq_d.size() !== 1) begin n_miss++; $display("FAIL len1_wcount: got %0d want 1", wq_d.size()); end
      else begin
         n_vec++;
         if ({wq_d[0], wq_s[0], wq_e[0]} !== {8'hA5, 1'b1, 1'b1}) begin
            n_miss++; $display("FAIL len1_wbyte: got %h %b %b want a5 1 1", wq_d[0], wq_s[0], wq_e[0]);
         end
      end
      n_vec++;
      if (op_a.size() != 3 || op_a[0] !== 24'h345000) begin
         n_miss++; $display("FAIL len1_erase_addr: ops %0d addr %h want 3 345000", op_a.size(), op_a.size() > 0 ? op_a[0] : 24'hx);
      end
      run_seq(24'h0000F0, 9'd16, 400);
      n_vec++;
      if ({got, d_pass, d_err} !== {1'b1, 1'b1, 9'd0}) begin
         n_miss++; $display("FAIL page_end_result: done %b pass %b err %0d want 1 1 0", got, d_pass, d_err);
      end
      n_vec++;
      if (op_t.size() !== 3) begin
         n_miss++; $display("FAIL page_end_ops: got %0d want 3", op_t.size());
      end
   endtask

   task automatic test_timeout();
      hang = 1;
      run_seq(24'h012300, 9'd16, 400);
      n_vec++;
      if (got !== 1'b1 || lat < 95 || lat > 110) begin
         n_miss++; $display("FAIL timeout_latency: done %b lat %0d want 1 95..110", got, lat);
      end
      n_vec++;
      if ({d_pass, d_err, d_opv, d_busy} !== {1'b0, 9'd0, 1'b0, 1'b0}) begin
         n_miss++; $display("FAIL timeout_result: pass %b err %0d opv %b busy %b want 0 0 0 0", d_pass, d_err, d_opv, d_busy);
      end
      n_vec++;
      if (op_t.size() !== 1) begin
         n_miss++; $display("FAIL timeout_ops: got %0d want 1", op_t.size());
      end
      hang = 0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad;
      repeat (5) @(negedge clk);
      clear_logs();
      base = 24'h012300; len = 9'd16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (write_valid && write_data == SEED + 8'd2) ok = 1;
         else @(negedge clk);
      end
      n_vec++;
      if (ok !== 1'b1) begin n_miss++; $display("FAIL rstmid_reach: got %b want 1", ok); end
      base = 24'h0; len = 9'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if ({busy, done, write_valid, write_data} !== {1'b1, 1'b0, 1'b1, SEED + 8'd3}) begin
         n_miss++; $display("FAIL busy_start_ignored: busy %b done %b wv %b data %h want 1 0 1 a8", busy, done, write_valid, write_data);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if ({write_valid, write_data} !== {1'b1, SEED + 8'd5}) begin
         n_miss++; $display("FAIL rstmid_byte5: wv %b data %h want 1 aa", write_valid, write_data);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({busy, done, pass, err_cnt, op_valid, op_type, op_addr, op_num,
           write_valid, write_sop, write_eop, write_data} !== '0) begin
         n_miss++; $display("FAIL rstmid_outputs: busy %b wv %b opv %b want all 0", busy, write_valid, op_valid);
      end
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (write_valid || op_valid || busy || done) bad++;
      end
      n_vec++;
      if (bad !== 0) begin n_miss++; $display("FAIL rstmid_quiet: active cycles %0d want 0", bad); end
      n_vec++;
      if (op_t.size() !== 2) begin n_miss++; $display("FAIL rstmid_ops: got %0d want 2", op_t.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_reject();
      test_short_eop();
      test_boundary();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
